vram_arbiter: RTL and testbench

Single-port arbiter and bank controller for the RX-78 six-plane VRAM (3 foreground + 3 background planes, 8 KB each). Owns the F1h/F2h read/write bank registers. Time-shares one synchronous-read plane array between the VDP pixel fetch and the Z80 VRAM window (EC00–FFFF). The VDP has priority; a bounded-starvation guarantee protects the CPU. Sits between T80s, the VDP and the six plane RAMs, replacing per-plane dual-port access.

---
 rtl/vram_arbiter.sv | 147 ++++++++++++++
 tb/tb_vram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port arbiter for the six VRAM planes: video fetch has priority, and a
// starvation counter forces a waiting Z80 access through after CPU_MAX_WAIT losses.
module vram_arbiter #(
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_wr,
  input  logic [7:0]  io_addr,
  input  logic [7:0]  io_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_wait_n,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic [47:0] vid_data,
  output logic        vid_valid,
  output logic        vid_overrun,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic [5:0]  ram_we,
  input  logic [47:0] ram_q
);
  localparam int SW = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [SW-1:0] MAX_W = SW'(CPU_MAX_WAIT);

  // state_q is the grant driving the RAM port in the current cycle.
  typedef enum logic [1:0] {IDLE, GRANT_V, GRANT_C} state_t;
  state_t state_q, state_d;

  logic [7:0]    rd_bank;
  logic [5:0]    wr_bank;
  logic          vid_pend, cpu_pend, cpu_we_q, cpu_gap_q, ack_we_q;
  logic [12:0]   vid_addr_q, cpu_addr_q;
  logic [7:0]    cpu_din_q, ack_rd_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          vid_valid_q, cpu_ack_q, vid_overrun_q;
  logic [12:0]   ram_addr_q;
  logic [7:0]    ram_din_q;
  logic [5:0]    ram_we_q;

  logic          cpu_new, c_avail, v_avail, c_we_eff;
  logic [12:0]   v_addr_eff, c_addr_eff;
  logic [7:0]    c_din_eff;

  always_comb begin
    // A new CPU request is ignored from grant until the cycle after its ack.
    cpu_new    = cpu_req && !cpu_pend && (state_q != GRANT_C) && !cpu_ack_q && !cpu_gap_q;
    c_avail    = cpu_pend || cpu_new;
    v_avail    = vid_pend || vid_req;
    v_addr_eff = vid_req ? vid_addr : vid_addr_q;
    c_addr_eff = cpu_pend ? cpu_addr_q : cpu_addr;
    c_din_eff  = cpu_pend ? cpu_din_q : cpu_din;
    c_we_eff   = cpu_pend ? cpu_we_q : cpu_we;

    state_d = IDLE;
    if (v_avail && (starve_q < MAX_W)) state_d = GRANT_V;
    else if (c_avail)                  state_d = GRANT_C;
    else if (v_avail)                  state_d = GRANT_V;

    starve_d = starve_q;
    if ((state_d == GRANT_C) || !c_avail) starve_d = '0;
    else if (starve_q < MAX_W)            starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      rd_bank       <= '0;
      wr_bank       <= '0;
      vid_pend      <= 1'b0;
      vid_addr_q    <= '0;
      vid_overrun_q <= 1'b0;
      cpu_pend      <= 1'b0;
      cpu_we_q      <= 1'b0;
      cpu_addr_q    <= '0;
      cpu_din_q     <= '0;
      cpu_gap_q     <= 1'b0;
      ack_we_q      <= 1'b0;
      ack_rd_q      <= '0;
      vid_valid_q   <= 1'b0;
      cpu_ack_q     <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_we_q      <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (io_wr && (io_addr == 8'hF1)) rd_bank <= io_data;
      if (io_wr && (io_addr == 8'hF2)) wr_bank <= io_data[5:0];

      vid_pend <= v_avail && (state_d != GRANT_V);
      if (vid_req) vid_addr_q <= vid_addr;
      if (vid_req && vid_pend) vid_overrun_q <= 1'b1;

      cpu_pend <= c_avail && (state_d != GRANT_C);
      if (cpu_new) begin
        cpu_we_q   <= cpu_we;
        cpu_addr_q <= cpu_addr;
        cpu_din_q  <= cpu_din;
      end

      ram_we_q <= '0;
      if (state_d == GRANT_V) ram_addr_q <= v_addr_eff;
      if (state_d == GRANT_C) begin
        ram_addr_q <= c_addr_eff;
        ram_din_q  <= c_din_eff;
        ram_we_q   <= c_we_eff ? wr_bank : 6'b0;
        ack_we_q   <= c_we_eff;
        ack_rd_q   <= rd_bank;
      end

      vid_valid_q <= (state_q == GRANT_V);
      cpu_ack_q   <= (state_q == GRANT_C);
      cpu_gap_q   <= cpu_ack_q;
    end
  end

  always_comb begin
    cpu_dout = 8'h00;
    if (cpu_ack_q && !ack_we_q) begin
      case (ack_rd_q)
        8'd1:    cpu_dout = ram_q[7:0];
        8'd2:    cpu_dout = ram_q[15:8];
        8'd3:    cpu_dout = ram_q[23:16];
        8'd4:    cpu_dout = ram_q[31:24];
        8'd5:    cpu_dout = ram_q[39:32];
        8'd6:    cpu_dout = ram_q[47:40];
        default: cpu_dout = 8'h00;
      endcase
    end
  end

  assign vid_data    = vid_valid_q ? ram_q : 48'h0;
  assign vid_valid   = vid_valid_q;
  assign vid_overrun = vid_overrun_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_wait_n  = ~(cpu_req & ~cpu_ack_q);
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign ram_we      = ram_we_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: plane-RAM model, reference memory and bank
// model in the bench, directed timing scenarios plus a randomized mixed phase.
module tb_vram_arbiter;
  localparam int CPU_MAX_WAIT = 4;

  logic        clk, reset;
  logic        io_wr;
  logic [7:0]  io_addr, io_data;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_ack, cpu_wait_n;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic [47:0] vid_data;
  logic        vid_valid, vid_overrun;
  logic [12:0] ram_addr;
  logic [7:0]  ram_din;
  logic [5:0]  ram_we;
  logic [47:0] ram_q;

  vram_arbiter #(.CPU_MAX_WAIT(CPU_MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .io_wr(io_wr), .io_addr(io_addr), .io_data(io_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .vid_overrun(vid_overrun), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_q(ram_q)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  // ---------------- plane RAM model and reference ----------------
  function automatic logic [7:0] pat(int p, int a);
    if (a < 'h100) return 8'h00;
    return 8'((a * 7) ^ (a >> 5) ^ (p * 29 + 1));
  endfunction

  logic [7:0] ram     [6][8192];
  logic [7:0] ref_mem [6][8192];
  bit         loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int p = 0; p < 6; p++)
        for (int a = 0; a < 8192; a++) ram[p][a] <= pat(p, a);
      loaded <= 1'b1;
    end else begin
      for (int p = 0; p < 6; p++)
        if (ram_we[p]) ram[p][ram_addr] <= ram_din;
    end
    ram_q <= {ram[5][ram_addr], ram[4][ram_addr], ram[3][ram_addr],
              ram[2][ram_addr], ram[1][ram_addr], ram[0][ram_addr]};
  end

  logic [7:0] rd_bank_m, wr_bank_m;

  function automatic logic [47:0] ref_word(logic [12:0] a);
    return {ref_mem[5][a], ref_mem[4][a], ref_mem[3][a],
            ref_mem[2][a], ref_mem[1][a], ref_mem[0][a]};
  endfunction

  function automatic logic [7:0] cpu_ref_read(logic [12:0] a);
    if (rd_bank_m >= 8'd1 && rd_bank_m <= 8'd6) return ref_mem[rd_bank_m - 1][a];
    return 8'h00;
  endfunction

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [47:0] vid_exp_q[$];
  logic [7:0]  cpu_exp_q[$];
  logic [5:0]  we_or;
  logic [12:0] we_addr;
  logic [7:0]  we_din;

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (vid_valid) begin
        if (vid_exp_q.size() == 0) chk("vid_unexpected_valid", 48'(vid_valid), 48'h0);
        else chk("vid_data", vid_data, vid_exp_q.pop_front());
      end
      if (cpu_ack) begin
        if (cpu_exp_q.size() == 0) chk("cpu_unexpected_ack", 48'(cpu_ack), 48'h0);
        else chk("cpu_dout", 48'(cpu_dout), 48'(cpu_exp_q.pop_front()));
      end
      if (ram_we != 6'b0) begin
        we_or   = we_or | ram_we;
        we_addr = ram_addr;
        we_din  = ram_din;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    io_wr = 1'b1; io_addr = a; io_data = d;
    if (a == 8'hF1) rd_bank_m = d;
    if (a == 8'hF2) wr_bank_m = d;
    tick();
    io_wr = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [12:0] a, input logic [7:0] d,
                            output int lat);
    bit got;
    if (we) begin
      cpu_exp_q.push_back(8'h00);
      for (int p = 0; p < 6; p++) if (wr_bank_m[p]) ref_mem[p][a] = d;
    end else begin
      cpu_exp_q.push_back(cpu_ref_read(a));
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    got = 1'b0; lat = -1;
    for (int c = 0; c <= CPU_MAX_WAIT + 4; c++) begin
      @(negedge clk);
      if (c == 0) chk("wait_n_pending", 48'(cpu_wait_n), 48'h0);
      if (cpu_ack) begin
        got = 1'b1; lat = c;
        chk("wait_n_at_ack", 48'(cpu_wait_n), 48'h1);
        break;
      end
    end
    checks++;
    if (!got || lat < 2 || lat > CPU_MAX_WAIT + 2) begin
      errors++;
      $display("FAIL cpu_ack_latency got=%0d exp=2..%0d", lat, CPU_MAX_WAIT + 2);
      if (!got) void'(cpu_exp_q.pop_back());
    end
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic vid_issue(input logic [12:0] a);
    vid_exp_q.push_back(ref_word(a));
    vid_req = 1'b1; vid_addr = a;
    tick();
    vid_req = 1'b0;
  endtask

  // Cycle-by-cycle scenario: video strobe on cycle c when vmask[c], its response
  // expected unless pmask[c] is clear; optional CPU read of 0200h raised on cycle 0.
  task automatic seq(input logic [15:0] vmask, input logic [15:0] pmask, input logic cpu_on,
                     input logic [12:0] base, input int ncyc,
                     output logic [15:0] vv, output int ack_cyc);
    vv = '0; ack_cyc = -1;
    if (cpu_on) cpu_exp_q.push_back(cpu_ref_read(13'h0200));
    for (int c = 0; c < ncyc; c++) begin
      vid_req  = vmask[c];
      vid_addr = 13'(base + c * 16);
      if (vmask[c] && pmask[c]) vid_exp_q.push_back(ref_word(vid_addr));
      cpu_req  = cpu_on && (ack_cyc < 0);
      cpu_we   = 1'b0;
      cpu_addr = 13'h0200;
      @(negedge clk);
      vv[c] = vid_valid;
      if (cpu_ack && ack_cyc < 0) ack_cyc = c;
      tick();
    end
    vid_req = 1'b0; cpu_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int          lat, ack_cyc;
  logic [15:0] vv;

  initial begin
    for (int p = 0; p < 6; p++)
      for (int a = 0; a < 8192; a++) ref_mem[p][a] = pat(p, a);
    rd_bank_m = 8'h00; wr_bank_m = 8'h00;
    we_or = '0; we_addr = '0; we_din = '0;
    reset = 1'b1; io_wr = 1'b0; io_addr = '0; io_data = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    vid_req = 1'b0; vid_addr = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cpu_ack", 48'(cpu_ack), 48'h0);
    chk("rst_vid_valid", 48'(vid_valid), 48'h0);
    chk("rst_vid_overrun", 48'(vid_overrun), 48'h0);
    chk("rst_ram_we", 48'(ram_we), 48'h0);
    chk("rst_wait_n", 48'(cpu_wait_n), 48'h1);
    tick();

    // Bank decode
    io_write(8'hF2, 8'h05);
    we_or = '0;
    cpu_access(1'b1, 13'h0010, 8'hA5, lat);
    chk("bank_wr_we", 48'(we_or), 48'b000101);
    chk("bank_wr_addr", 48'(we_addr), 48'h0010);
    chk("bank_wr_din", 48'(we_din), 48'hA5);
    chk("idle_cpu_latency", 48'(lat), 48'd2);
    io_write(8'hF1, 8'h01); cpu_access(1'b0, 13'h0010, 8'h00, lat);
    io_write(8'hF1, 8'h02); cpu_access(1'b0, 13'h0010, 8'h00, lat);
    io_write(8'hF1, 8'h07); cpu_access(1'b0, 13'h0010, 8'h00, lat);

    // Write with no planes enabled
    io_write(8'hF2, 8'h00);
    we_or = '0;
    cpu_access(1'b1, 13'h0120, 8'h5A, lat);
    chk("wb0_latency", 48'(lat), 48'd2);
    chk("wb0_ram_we", 48'(we_or), 48'h0);
    for (int r = 1; r <= 6; r++) begin
      io_write(8'hF1, 8'(r));
      cpu_access(1'b0, 13'h0120, 8'h00, lat);
    end

    // Simultaneous requests from idle
    io_write(8'hF1, 8'h03);
    seq(16'h0001, 16'h0001, 1'b1, 13'h0100, 6, vv, ack_cyc);
    chk("simul_vid_valid_cycles", 48'(vv), 48'h0004);
    chk("simul_ack_cycle", 48'(ack_cyc), 48'd3);

    // Starvation: five back-to-back strobes against a held CPU read
    seq(16'h001F, 16'h001F, 1'b1, 13'h1000, 10, vv, ack_cyc);
    chk("starve_ack_cycle", 48'(ack_cyc), 48'd6);
    chk("starve_vid_valid_cycles", 48'(vv), 48'h00BC);
    chk("starve_no_overrun", 48'(vid_overrun), 48'h0);

    // Randomized mixed traffic; video reads a region the CPU never writes
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          if ($urandom_range(0, 3) == 0) io_write(8'hF1, 8'($urandom_range(0, 7)));
          if ($urandom_range(0, 3) == 0) io_write(8'hF2, 8'($urandom_range(0, 255)));
          cpu_access(1'($urandom_range(0, 1)), 13'(13'h0300 + $urandom_range(0, 7)),
                     8'($urandom_range(0, 255)), lat);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          vid_issue(13'(13'h1000 + $urandom_range(0, 'hFFF)));
          repeat ($urandom_range(1, 3)) tick();
        end
      end
    join
    repeat (8) tick();
    chk("rand_vid_drained", 48'(vid_exp_q.size()), 48'h0);
    chk("rand_cpu_drained", 48'(cpu_exp_q.size()), 48'h0);
    chk("rand_no_overrun", 48'(vid_overrun), 48'h0);

    // Overrun: a second strobe replaces the one displaced by the forced CPU grant
    seq(16'h003F, 16'h002F, 1'b1, 13'h1400, 10, vv, ack_cyc);
    chk("ovr_ack_cycle", 48'(ack_cyc), 48'd6);
    chk("ovr_vid_valid_cycles", 48'(vv), 48'h00BC);
    chk("ovr_flag", 48'(vid_overrun), 48'h1);
    repeat (5) tick();
    chk("ovr_flag_sticky", 48'(vid_overrun), 48'h1);
    chk("ovr_vid_drained", 48'(vid_exp_q.size()), 48'h0);

    // Reset during a CPU grant
    io_write(8'hF1, 8'h01);
    io_write(8'hF2, 8'h03);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0200;
    tick();
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    rd_bank_m = 8'h00; wr_bank_m = 8'h00;
    @(negedge clk);
    chk("mrst_cpu_ack", 48'(cpu_ack), 48'h0);
    chk("mrst_cpu_dout", 48'(cpu_dout), 48'h0);
    chk("mrst_vid_valid", 48'(vid_valid), 48'h0);
    chk("mrst_vid_data", vid_data, 48'h0);
    chk("mrst_vid_overrun", 48'(vid_overrun), 48'h0);
    chk("mrst_ram_addr", 48'(ram_addr), 48'h0);
    chk("mrst_ram_din", 48'(ram_din), 48'h0);
    chk("mrst_ram_we", 48'(ram_we), 48'h0);
    chk("mrst_wait_n", 48'(cpu_wait_n), 48'h1);
    repeat (4) tick();
    cpu_access(1'b0, 13'h0200, 8'h00, lat);
    we_or = '0;
    cpu_access(1'b1, 13'h0300, 8'h77, lat);
    chk("mrst_wr_bank_zero", 48'(we_or), 48'h0);
    repeat (4) tick();
    chk("final_cpu_drained", 48'(cpu_exp_q.size()), 48'h0);
    chk("final_vid_drained", 48'(vid_exp_q.size()), 48'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
